operand_fetch_unit: RTL and testbench
=====================================

# operand_fetch_unit

Client-side controller for the 8-entry register file: accepts decoded instructions over a valid/ready handshake, drives the file's read indices, captures S1/S2 and presents the operands downstream. It also forwards writebacks onto the file's write port and keeps a scoreboard of pending destination registers to stall RAW and WAW hazards. It sits between decode and execute, in front of the register file.

## Interface
- index_width, 3, register index width; the scoreboard has 1<<index_width bits
- reg_width, 32, data width
- clk  in  1  clock; all state updates on posedge
- rstn  in  1  asynchronous active-low reset
- iss_valid  in  1  instruction offered
- iss_ready  out  1  instruction accepted this cycle when iss_valid && iss_ready
- iss_rs1, iss_rs2, iss_rd  in  index_width  source/destination indices
- iss_wr  in  1  instruction will write iss_rd
- opd_valid  out  1  operands valid
- opd_ready  in  1  downstream accepts operands
- opd_a, opd_b  out  reg_width  R[rs1], R[rs2]
- opd_rd  out  index_width  destination index
- opd_wr  out  1  copy of iss_wr
- wb_valid  in  1  writeback strobe, always accepted
- wb_rd  in  index_width  writeback index
- wb_data  in  reg_width  writeback data
- rf_we  out  1  to register-file we
- rf_op0, rf_op1, rf_op2  out  index_width  to register-file op0/op1/op2
- rf_d  out  reg_width  to register-file D
- rf_s1, rf_s2  in  reg_width  from register-file S1/S2

## Operation
- Writeback path is combinational: rf_we = wb_valid && rstn, rf_op0 = wb_rd, rf_d = wb_data. The file writes on the negedge of the same cycle. On wb_valid, clear scoreboard bit wb_rd.
- Hazard = sb[iss_rs1] | sb[iss_rs2] | (iss_wr & sb[iss_rd]).
- iss_ready = rstn && !hazard && (state==IDLE || (state==HOLD && opd_ready)).
- FSM:
  - IDLE: on accept, register rs1/rs2 into rf_op1/rf_op2, latch rd/wr, set sb[rd] if wr, go to FETCH.
  - FETCH: the file samples the indices at the closing edge. Go to LOAD.
  - LOAD: rf_s1/rf_s2 are valid. At the closing edge: opd_a <= rf_s1, opd_b <= rf_s2, opd_valid <= 1, go to HOLD.
  - HOLD: hold all opd_* stable while !opd_ready. When opd_ready, clear opd_valid and go to IDLE, or go to FETCH if a new instruction is accepted in the same cycle.
- rf_op1/rf_op2 stay constant from accept through LOAD.
- Scoreboard set and clear on the same index in the same cycle: set wins.
- Writeback to an index that is not pending: the file is written and the scoreboard is unchanged.
- Reset asserted mid-operation: the in-flight instruction is dropped, the scoreboard is cleared, and the FSM returns to IDLE.

## Timing
- Reset values:
  - state IDLE, scoreboard all 0.
  - opd_valid 0, opd_a 0, opd_b 0, opd_rd 0, opd_wr 0, rf_op1 0, rf_op2 0.
  - iss_ready 0 while rstn is low.
- Latency: accept at edge P0, opd_valid high after edge P2 (2 cycles).
- Throughput: one instruction per 3 cycles when opd_ready is held high.
- The file is write-before-read: a writeback in the FETCH cycle is visible in rf_s1/rf_s2 during LOAD.
- A register becomes issuable the cycle after its wb_valid. The bypass feature below shortens this.

## Configuration
- OPERAND_FETCH_WB_BYPASS_EN defined: hazard ignores scoreboard bit wb_rd when wb_valid is high. An instruction waiting on wb_rd is therefore accepted in the same cycle as its writeback. This is safe because the negedge write lands before FETCH sampling.
- OPERAND_FETCH_WB_BYPASS_EN undefined: hazard uses registered scoreboard bits only, costing a one-cycle stall per dependency.

## Test plan
- Reset with R3=0x11 and R5=0x22 preloaded: issue rs1=3, rs2=5, rd=1, wr=1 with opd_ready=1. Required: opd_valid after 2 cycles, opd_a=0x11, opd_b=0x22, opd_rd=1, sb[1]=1.
- RAW: issue rd=2 wr=1, then issue rs1=2. Required: iss_ready=0 until wb_valid with rd=2, data=0xABCD. Required after that: second opd_a=0xABCD. Accept is the same cycle as wb_valid with the macro, and the next cycle without it.
- WAW: pending rd=4, offer another instruction with rd=4 wr=1. Required: stalled until wb_rd=4. An instruction with iss_wr=0 and rd=4 and clean sources is accepted.
- Backpressure: opd_ready=0 for 5 cycles in HOLD. Required: opd_* stable and iss_ready=0. Then opd_ready=1 with iss_valid: handoff and accept in the same cycle, state FETCH.
- Reset pulse during FETCH: required are opd_valid=0, scoreboard all 0, no opd_valid pulse afterwards, and rf_we=0 while rstn is low.
- Stray writeback wb_rd=6 with nothing pending: required are that R6 is written and the scoreboard remains all 0.

Source files
------------

// File: rtl/operand_fetch_unit.sv
// Operand fetch for an 8-entry register file with a RAW/WAW pending-destination scoreboard.
// Define OPERAND_FETCH_WB_BYPASS_EN to let a same-cycle writeback release a stalled instruction.
module operand_fetch_unit #(
   parameter int index_width = 3,
   parameter int reg_width   = 32
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   iss_valid,
   output logic                   iss_ready,
   input  logic [index_width-1:0] iss_rs1,
   input  logic [index_width-1:0] iss_rs2,
   input  logic [index_width-1:0] iss_rd,
   input  logic                   iss_wr,
   output logic                   opd_valid,
   input  logic                   opd_ready,
   output logic [reg_width-1:0]   opd_a,
   output logic [reg_width-1:0]   opd_b,
   output logic [index_width-1:0] opd_rd,
   output logic                   opd_wr,
   input  logic                   wb_valid,
   input  logic [index_width-1:0] wb_rd,
   input  logic [reg_width-1:0]   wb_data,
   output logic                   rf_we,
   output logic [index_width-1:0] rf_op0,
   output logic [index_width-1:0] rf_op1,
   output logic [index_width-1:0] rf_op2,
   output logic [reg_width-1:0]   rf_d,
   input  logic [reg_width-1:0]   rf_s1,
   input  logic [reg_width-1:0]   rf_s2
);

   localparam int n_regs = 1 << index_width;

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [n_regs-1:0]      r_sb;
   logic [n_regs-1:0]      w_sb_set;
   logic [n_regs-1:0]      w_sb_clr;
   logic [n_regs-1:0]      w_sb_view;
   logic [index_width-1:0] r_rd;
   logic                   r_wr;
   logic                   w_hazard;
   logic                   w_accept;

   // The file writes on the negedge, so the writeback port is a pure pass-through.
   assign rf_we  = wb_valid && rstn;
   assign rf_op0 = wb_rd;
   assign rf_d   = wb_data;

   // NOTE: every signal written in an always_comb gets a default first; a path that
   // leaves one unassigned infers a latch.
   always_comb begin
      w_sb_clr = '0;
      w_sb_set = '0;
      if (wb_valid)
         w_sb_clr[wb_rd] = 1'b1;
      if (w_accept && iss_wr)
         w_sb_set[iss_rd] = 1'b1;
   end

`ifdef OPERAND_FETCH_WB_BYPASS_EN
   assign w_sb_view = r_sb & ~w_sb_clr;
`else
   assign w_sb_view = r_sb;
`endif

   assign w_hazard = w_sb_view[iss_rs1] | w_sb_view[iss_rs2] | (iss_wr & w_sb_view[iss_rd]);

   always_comb begin
      iss_ready    = rstn && !w_hazard &&
                     ((r_state == IDLE) || ((r_state == HOLD) && opd_ready));
      w_accept     = iss_valid && iss_ready;
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = FETCH;
         FETCH:   w_state_next = LOAD;
         LOAD:    w_state_next = HOLD;
         HOLD:    if (opd_ready) w_state_next = w_accept ? FETCH : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sb      <= '0;
         r_rd      <= '0;
         r_wr      <= 1'b0;
         rf_op1    <= '0;
         rf_op2    <= '0;
         opd_valid <= 1'b0;
         opd_a     <= '0;
         opd_b     <= '0;
         opd_rd    <= '0;
         opd_wr    <= 1'b0;
      end else begin
         // Set after clear: a new pending write outranks a writeback to the same index.
         r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
         if (w_accept) begin
            rf_op1 <= iss_rs1;
            rf_op2 <= iss_rs2;
            r_rd   <= iss_rd;
            r_wr   <= iss_wr;
         end
         if (r_state == LOAD) begin
            opd_a     <= rf_s1;
            opd_b     <= rf_s2;
            opd_rd    <= r_rd;
            opd_wr    <= r_wr;
            opd_valid <= 1'b1;
         end else if ((r_state == HOLD) && opd_ready) begin
            opd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Self-checking bench for operand_fetch_unit: register-file model, expected-operand queue,
// table-driven issue vectors and hand-written hazard/backpressure/reset sequences.
module tb_operand_fetch_unit;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
   localparam int WB_WAIT = 0;
`else
   localparam int WB_WAIT = 1;
`endif

   logic        clk;
   logic        rstn;
   logic        iss_valid;
   logic        iss_ready;
   logic [2:0]  iss_rs1, iss_rs2, iss_rd;
   logic        iss_wr;
   logic        opd_valid;
   logic        opd_ready;
   logic [31:0] opd_a, opd_b;
   logic [2:0]  opd_rd;
   logic        opd_wr;
   logic        wb_valid;
   logic [2:0]  wb_rd;
   logic [31:0] wb_data;
   logic        rf_we;
   logic [2:0]  rf_op0, rf_op1, rf_op2;
   logic [31:0] rf_d;
   logic [31:0] rf_s1, rf_s2;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  rd;
      logic        wr;
   } exp_t;

   typedef struct {
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [2:0]  rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        vecs[6];
   logic [31:0] rf_mem[8];
   logic [31:0] gold[8];
   int          n_checks = 0;
   int          n_errors = 0;

   operand_fetch_unit dut (
      .clk       (clk),
      .rstn      (rstn),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .iss_wr    (iss_wr),
      .opd_valid (opd_valid),
      .opd_ready (opd_ready),
      .opd_a     (opd_a),
      .opd_b     (opd_b),
      .opd_rd    (opd_rd),
      .opd_wr    (opd_wr),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .rf_we     (rf_we),
      .rf_op0    (rf_op0),
      .rf_op1    (rf_op1),
      .rf_op2    (rf_op2),
      .rf_d      (rf_d),
      .rf_s1     (rf_s1),
      .rf_s2     (rf_s2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: negedge write, indices sampled at posedge (write-before-read).
   always @(negedge clk) if (rf_we) rf_mem[rf_op0] <= rf_d;
   always @(posedge clk) begin
      rf_s1 <= rf_mem[rf_op1];
      rf_s2 <= rf_mem[rf_op2];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Operand handshakes are compared against the queue at the negedge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (rstn && opd_valid && opd_ready) begin
         if (exp_q.size() == 0) begin
            check("opd_unexpected", opd_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("opd_a", opd_a, e.a);
            check("opd_b", opd_b, e.b);
            check("opd_rd", opd_rd, e.rd);
            check("opd_wr", opd_wr, e.wr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (3) tick();
   endtask

   // Offers one instruction (optionally with a writeback in the first cycle) until accepted.
   // waited = cycles before acceptance, or -1 when the bound expires.
   task automatic offer(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                        input logic wr, input logic wb_en, input logic [2:0] wbrd,
                        input logic [31:0] wbd, input logic [31:0] ea, input logic [31:0] eb,
                        output int waited);
      bit done;
      iss_valid = 1'b1;
      iss_rs1   = rs1;
      iss_rs2   = rs2;
      iss_rd    = rd;
      iss_wr    = wr;
      wb_valid  = wb_en;
      wb_rd     = wbrd;
      wb_data   = wbd;
      if (wb_en) gold[wbrd] = wbd;
      waited = 0;
      done   = 1'b0;
      while (!done) begin
         #2;
         if (iss_ready) begin
            exp_q.push_back('{a: ea, b: eb, rd: rd, wr: wr});
            done = 1'b1;
         end else if (waited == 6) begin
            waited = -1;
            done   = 1'b1;
         end else begin
            waited++;
         end
         tick();
         wb_valid = 1'b0;
      end
      iss_valid = 1'b0;
   endtask

   task automatic expect_stall(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                               input logic wr, input int n, input string name);
      iss_valid = 1'b1;
      iss_rs1   = rs1;
      iss_rs2   = rs2;
      iss_rd    = rd;
      iss_wr    = wr;
      repeat (n) begin
         #2;
         check(name, iss_ready, 1'b0);
         tick();
      end
      iss_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;

      vecs[0] = '{3'd0, 3'd7, 3'd3, 1'b0, 32'hA0,   32'hA7};
      vecs[1] = '{3'd1, 3'd2, 3'd6, 1'b0, 32'h5555, 32'hABCD};
      vecs[2] = '{3'd3, 3'd3, 3'd0, 1'b0, 32'h11,   32'h11};
      vecs[3] = '{3'd4, 3'd5, 3'd7, 1'b0, 32'h4545, 32'h22};
      vecs[4] = '{3'd6, 3'd1, 3'd2, 1'b0, 32'hA6,   32'h5555};
      vecs[5] = '{3'd7, 3'd0, 3'd5, 1'b0, 32'hA7,   32'hA0};

      for (int i = 0; i < 8; i++) begin
         rf_mem[i] = 32'hA0 + 32'(i);
         gold[i]   = 32'hA0 + 32'(i);
      end
      rf_mem[3] = 32'h11; gold[3] = 32'h11;
      rf_mem[5] = 32'h22; gold[5] = 32'h22;

      // Reset: a writeback offered during reset must not reach the file.
      rstn      = 1'b0;
      iss_valid = 1'b1;
      iss_rs1   = '0;
      iss_rs2   = '0;
      iss_rd    = '0;
      iss_wr    = 1'b0;
      opd_ready = 1'b1;
      wb_valid  = 1'b1;
      wb_rd     = 3'd7;
      wb_data   = 32'hBAD0;
      repeat (2) @(posedge clk);
      #3;
      check("rst_iss_ready", iss_ready, 1'b0);
      check("rst_opd_valid", opd_valid, 1'b0);
      check("rst_opd_a", opd_a, 32'h0);
      check("rst_opd_b", opd_b, 32'h0);
      check("rst_opd_rd", opd_rd, 3'd0);
      check("rst_opd_wr", opd_wr, 1'b0);
      check("rst_rf_op1", rf_op1, 3'd0);
      check("rst_rf_op2", rf_op2, 3'd0);
      check("rst_rf_we", rf_we, 1'b0);
      tick();
      rstn      = 1'b1;
      wb_valid  = 1'b0;
      iss_valid = 1'b0;
      check("rst_rf_no_write", rf_mem[7], 32'hA7);

      // Basic fetch and 2-cycle latency.
      offer(3'd3, 3'd5, 3'd1, 1'b1, 1'b0, 3'd0, 32'h0, 32'h11, 32'h22, w);
      check("t1_accept_wait", w, 0);
      #2; check("lat_p0", opd_valid, 1'b0);
      tick();
      #2; check("lat_p1", opd_valid, 1'b0);
      tick();
      #2; check("lat_p2", opd_valid, 1'b1);
      check("t1_opd_a", opd_a, 32'h11);
      check("t1_opd_b", opd_b, 32'h22);
      check("t1_opd_rd", opd_rd, 3'd1);
      tick();
      expect_stall(3'd1, 3'd0, 3'd0, 1'b0, 2, "t1_sb1_stall");
      offer(3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 3'd1, 32'h5555, 32'h5555, 32'hA0, w);
      check("t1_wb_accept_wait", w, WB_WAIT);
      drain();

      // RAW on R2.
      offer(3'd0, 3'd3, 3'd2, 1'b1, 1'b0, 3'd0, 32'h0, 32'hA0, 32'h11, w);
      check("raw_producer_wait", w, 0);
      drain();
      expect_stall(3'd2, 3'd3, 3'd0, 1'b0, 3, "raw_stall");
      offer(3'd2, 3'd3, 3'd0, 1'b0, 1'b1, 3'd2, 32'hABCD, 32'hABCD, 32'h11, w);
      check("raw_accept_wait", w, WB_WAIT);
      drain();

      // WAW on R4; a non-writing instruction naming rd=4 is not blocked.
      offer(3'd0, 3'd1, 3'd4, 1'b1, 1'b0, 3'd0, 32'h0, 32'hA0, 32'h5555, w);
      check("waw_producer_wait", w, 0);
      drain();
      expect_stall(3'd0, 3'd0, 3'd4, 1'b1, 2, "waw_stall");
      offer(3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 3'd0, 32'h0, 32'hA0, 32'hA0, w);
      check("waw_nowr_accept", w, 0);
      drain();
      offer(3'd3, 3'd5, 3'd4, 1'b1, 1'b1, 3'd4, 32'h4444, 32'h11, 32'h22, w);
      check("waw_accept_wait", w, WB_WAIT);
      drain();
      expect_stall(3'd4, 3'd0, 3'd0, 1'b0, 1, "waw_repending_stall");
      offer(3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 3'd4, 32'h4545, 32'h4545, 32'hA0, w);
      check("waw_clear_wait", w, WB_WAIT);
      drain();

      // Back-to-back table vectors: accept every third cycle.
      for (int i = 0; i < 6; i++) begin
         offer(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wr, 1'b0, 3'd0, 32'h0,
               vecs[i].a, vecs[i].b, w);
         check("vec_accept_wait", w, (i == 0) ? 0 : 2);
      end
      drain();

      // Backpressure in HOLD, then handoff with a same-cycle accept.
      opd_ready = 1'b0;
      offer(3'd6, 3'd7, 3'd3, 1'b1, 1'b0, 3'd0, 32'h0, 32'hA6, 32'hA7, w);
      check("bp_first_wait", w, 0);
      repeat (2) tick();
      iss_valid = 1'b1;
      iss_rs1   = 3'd0;
      iss_rs2   = 3'd5;
      iss_rd    = 3'd1;
      iss_wr    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #2;
         check("bp_iss_ready", iss_ready, 1'b0);
         check("bp_opd_valid", opd_valid, 1'b1);
         check("bp_opd_a", opd_a, 32'hA6);
         check("bp_opd_b", opd_b, 32'hA7);
         check("bp_opd_rd", opd_rd, 3'd3);
         check("bp_opd_wr", opd_wr, 1'b1);
         tick();
      end
      opd_ready = 1'b1;
      offer(3'd0, 3'd5, 3'd1, 1'b0, 1'b0, 3'd0, 32'h0, 32'hA0, 32'h22, w);
      check("bp_handoff_wait", w, 0);
      #2; check("bp_fetch", opd_valid, 1'b0);
      tick();
      #2; check("bp_load", opd_valid, 1'b0);
      tick();
      #2; check("bp_hold", opd_valid, 1'b1);
      tick();
      offer(3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 32'h11, 32'h11, 32'h11, w);
      check("bp_clear_wait", w, WB_WAIT);
      drain();

      // Reset pulse during FETCH drops the in-flight instruction.
      offer(3'd2, 3'd4, 3'd5, 1'b1, 1'b0, 3'd0, 32'h0, 32'hABCD, 32'h4545, w);
      check("rp_accept_wait", w, 0);
      void'(exp_q.pop_back());
      #1;
      rstn      = 1'b0;
      wb_valid  = 1'b1;
      wb_rd     = 3'd3;
      wb_data   = 32'hDEAD;
      iss_valid = 1'b1;
      iss_rs1   = 3'd0;
      iss_rs2   = 3'd0;
      iss_wr    = 1'b0;
      #1;
      check("rp_opd_valid", opd_valid, 1'b0);
      check("rp_opd_a", opd_a, 32'h0);
      check("rp_rf_op1", rf_op1, 3'd0);
      check("rp_rf_op2", rf_op2, 3'd0);
      check("rp_rf_we", rf_we, 1'b0);
      check("rp_iss_ready", iss_ready, 1'b0);
      tick();
      #2; check("rp_rf_we_hold", rf_we, 1'b0);
      tick();
      rstn      = 1'b1;
      wb_valid  = 1'b0;
      iss_valid = 1'b0;
      check("rp_rf_no_write", rf_mem[3], 32'h11);
      for (int i = 0; i < 5; i++) begin
         #2; check("rp_no_opd_pulse", opd_valid, 1'b0);
         tick();
      end
      offer(3'd5, 3'd5, 3'd0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h22, 32'h22, w);
      check("rp_sb_cleared", w, 0);
      drain();

      // Stray writeback, then set-wins on a same-cycle set/clear of R6.
      wb_valid = 1'b1;
      wb_rd    = 3'd6;
      wb_data  = 32'h6666;
      gold[6]  = 32'h6666;
      tick();
      wb_valid = 1'b0;
      check("stray_rf_write", rf_mem[6], 32'h6666);
      offer(3'd0, 3'd0, 3'd6, 1'b1, 1'b1, 3'd6, 32'h6767, 32'hA0, 32'hA0, w);
      check("setwins_accept_wait", w, 0);
      drain();
      expect_stall(3'd6, 3'd0, 3'd0, 1'b0, 1, "setwins_stall");
      offer(3'd6, 3'd0, 3'd0, 1'b0, 1'b1, 3'd6, 32'h6868, 32'h6868, 32'hA0, w);
      check("setwins_clear_wait", w, WB_WAIT);
      drain();

      // Every register issuable: scoreboard all clear.
      for (int i = 0; i < 8; i++) begin
         offer(3'(i), 3'(7 - i), 3'(i), 1'b0, 1'b0, 3'd0, 32'h0, gold[i], gold[7 - i], w);
         check("sweep_accept_wait", w, (i == 0) ? 0 : 2);
      end
      drain();
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
